// File: rtl/acs_unit.sv
// Add-compare-select stage for the K=3 rate-1/2 (7,5) Viterbi decoder, with frame tracking.
// Optional ACS_NORM_STATS_EN adds a saturating count of normalized symbols (norm_cnt).
module acs_unit #(
  parameter int FRAME_LEN   = 64,
  parameter int INIT_BIAS   = 8,
  parameter int NORM_THRESH = 16,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             frame_start,
  input  logic [1:0]       sym,
  input  logic [4:0]       m_in0,
  input  logic [4:0]       m_in1,
  input  logic [4:0]       m_in2,
  input  logic [4:0]       m_in3,
  output logic [4:0]       m_new0,
  output logic [4:0]       m_new1,
  output logic [4:0]       m_new2,
  output logic [4:0]       m_new3,
  output logic [3:0]       dec,
  output logic             dec_valid,
  output logic [1:0]       best_state,
  output logic [CNT_W-1:0] sym_idx,
  output logic             frame_done
`ifdef ACS_NORM_STATS_EN
  ,
  output logic [7:0]       norm_cnt
`endif
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       dec_q, dec_d;
  logic             dec_valid_q, dec_valid_d;
  logic [1:0]       best_state_q, best_state_d;
  logic [CNT_W-1:0] sym_idx_q, sym_idx_d;
  logic             frame_done_q, frame_done_d;

  logic [4:0]       old_m [4];
  logic [4:0]       acs_m [4];
  logic [4:0]       norm_m [4];
  logic [3:0]       sel;
  logic [4:0]       min_m;
  logic [1:0]       min_idx;
  logic             norm_fire;
  logic             accept;
  logic [CNT_W-1:0] cur_idx;
  logic             last_sym;
  logic [1:0]       nn, p0, p1;
  logic [4:0]       cand_a, cand_b;

  function automatic logic [1:0] branch_metric(input logic [1:0] n, input logic [1:0] p,
                                               input logic [1:0] s);
    logic c1, c0;
    c1 = n[1] ^ p[1] ^ p[0];
    c0 = n[1] ^ p[0];
    return {1'b0, c1 ^ s[1]} + {1'b0, c0 ^ s[0]};
  endfunction

  function automatic logic [4:0] sat_add(input logic [4:0] m, input logic [1:0] bm);
    logic [5:0] sum;
    sum = {1'b0, m} + {4'b0000, bm};
    return (sum > 6'd31) ? 5'd31 : sum[4:0];
  endfunction

  // A frame_start symbol discards the incoming metrics and seeds state 0 as most likely.
  always_comb begin
    old_m[0] = frame_start ? 5'd0 : m_in0;
    old_m[1] = frame_start ? 5'(INIT_BIAS) : m_in1;
    old_m[2] = frame_start ? 5'(INIT_BIAS) : m_in2;
    old_m[3] = frame_start ? 5'(INIT_BIAS) : m_in3;
    nn      = '0;
    p0      = '0;
    p1      = '0;
    cand_a  = '0;
    cand_b  = '0;
    sel     = '0;
    acs_m   = '{default: '0};
    norm_m  = '{default: '0};
    for (int i = 0; i < 4; i++) begin
      nn       = 2'(i);
      p0       = {nn[0], 1'b0};
      p1       = {nn[0], 1'b1};
      cand_a   = sat_add(old_m[p0], branch_metric(nn, p0, sym));
      cand_b   = sat_add(old_m[p1], branch_metric(nn, p1, sym));
      sel[i]   = cand_b < cand_a;
      acs_m[i] = sel[i] ? cand_b : cand_a;
    end
    min_m   = acs_m[0];
    min_idx = '0;
    for (int i = 1; i < 4; i++) begin
      if (acs_m[i] < min_m) begin
        min_m   = acs_m[i];
        min_idx = 2'(i);
      end
    end
    norm_fire = {1'b0, min_m} >= 6'(NORM_THRESH);
    for (int i = 0; i < 4; i++) begin
      norm_m[i] = norm_fire ? acs_m[i] - 5'(NORM_THRESH) : acs_m[i];
    end
  end

  always_comb begin
    accept       = in_valid && (state_q == RUN || frame_start);
    cur_idx      = frame_start ? '0 : cnt_q;
    last_sym     = cur_idx == CNT_W'(FRAME_LEN - 1);
    state_d      = state_q;
    cnt_d        = cnt_q;
    dec_d        = dec_q;
    best_state_d = best_state_q;
    sym_idx_d    = sym_idx_q;
    dec_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    if (accept) begin
      dec_valid_d  = 1'b1;
      dec_d        = sel;
      best_state_d = min_idx;
      sym_idx_d    = cur_idx;
      if (last_sym) begin
        state_d      = IDLE;
        cnt_d        = '0;
        frame_done_d = 1'b1;
      end else begin
        state_d = RUN;
        cnt_d   = cur_idx + CNT_W'(1);
      end
    end
    m_new0 = reset ? 5'd0 : (accept ? norm_m[0] : m_in0);
    m_new1 = reset ? 5'd0 : (accept ? norm_m[1] : m_in1);
    m_new2 = reset ? 5'd0 : (accept ? norm_m[2] : m_in2);
    m_new3 = reset ? 5'd0 : (accept ? norm_m[3] : m_in3);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      dec_q        <= '0;
      dec_valid_q  <= 1'b0;
      best_state_q <= '0;
      sym_idx_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dec_q        <= dec_d;
      dec_valid_q  <= dec_valid_d;
      best_state_q <= best_state_d;
      sym_idx_q    <= sym_idx_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign dec        = dec_q;
  assign dec_valid  = dec_valid_q;
  assign best_state = best_state_q;
  assign sym_idx    = sym_idx_q;
  assign frame_done = frame_done_q;

`ifdef ACS_NORM_STATS_EN
  logic [7:0] norm_cnt_q, norm_cnt_d;
  logic [7:0] norm_base;

  // A new frame restarts the count, then its own symbol may still count as one.
  always_comb begin
    norm_base  = (accept && frame_start) ? 8'd0 : norm_cnt_q;
    norm_cnt_d = norm_cnt_q;
    if (accept) begin
      norm_cnt_d = (norm_fire && norm_base != 8'hFF) ? norm_base + 8'd1 : norm_base;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      norm_cnt_q <= '0;
    end else begin
      norm_cnt_q <= norm_cnt_d;
    end
  end

  assign norm_cnt = norm_cnt_q;
`endif

endmodule

// File: tb/tb_acs_unit.sv
// Scoreboard bench for acs_unit: an encoder-level trellis model predicts metrics and decisions,
// and a monitor pops expected decisions whenever dec_valid is presented.
module tb_acs_unit;
  localparam int FRAME_LEN   = 4;
  localparam int INIT_BIAS   = 8;
  localparam int NORM_THRESH = 16;
  localparam int CNT_W       = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             frame_start;
  logic [1:0]       sym;
  logic [4:0]       m_in0, m_in1, m_in2, m_in3;
  logic [4:0]       m_new0, m_new1, m_new2, m_new3;
  logic [3:0]       dec;
  logic             dec_valid;
  logic [1:0]       best_state;
  logic [CNT_W-1:0] sym_idx;
  logic             frame_done;
`ifdef ACS_NORM_STATS_EN
  logic [7:0]       norm_cnt;
`endif

  acs_unit #(
    .FRAME_LEN(FRAME_LEN), .INIT_BIAS(INIT_BIAS), .NORM_THRESH(NORM_THRESH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .frame_start(frame_start), .sym(sym),
    .m_in0(m_in0), .m_in1(m_in1), .m_in2(m_in2), .m_in3(m_in3),
    .m_new0(m_new0), .m_new1(m_new1), .m_new2(m_new2), .m_new3(m_new3),
    .dec(dec), .dec_valid(dec_valid), .best_state(best_state), .sym_idx(sym_idx),
    .frame_done(frame_done)
`ifdef ACS_NORM_STATS_EN
    , .norm_cnt(norm_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int               cyc;
    logic [3:0]       dec;
    logic [1:0]       best;
    logic [CNT_W-1:0] idx;
    logic             fd;
  } rec_t;

  rec_t sb_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc_cnt = 0;
  bit   mon_en = 0;
  bit   nc_known = 0;
  int   model_old[4];
  int   exp_m[4];
  int   exp_dec, exp_best;
  bit   exp_fired;
  bit   model_running = 0;
  int   model_idx = 0;
  int   model_nc = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Walk every (state, input bit) pair of the shift-register encoder and keep the best entry per
  // destination; earlier predecessors win ties because only a strictly smaller candidate replaces.
  task automatic modelAcs(input int s);
    int bestm[4];
    int pick[4];
    int b1, b2, c1, c0, n, bm, cand;
    for (int k = 0; k < 4; k++) begin
      bestm[k] = 1000;
      pick[k]  = 0;
    end
    for (int p = 0; p < 4; p++) begin
      for (int u = 0; u < 2; u++) begin
        b1 = (p >> 1) & 1;
        b2 = p & 1;
        c1 = u ^ b1 ^ b2;
        c0 = u ^ b2;
        n  = u * 2 + b1;
        bm = ((c1 != ((s >> 1) & 1)) ? 1 : 0) + ((c0 != (s & 1)) ? 1 : 0);
        cand = model_old[p] + bm;
        if (cand > 31) cand = 31;
        if (cand < bestm[n]) begin
          bestm[n] = cand;
          pick[n]  = b2;
        end
      end
    end
    exp_best = 0;
    for (int k = 1; k < 4; k++) if (bestm[k] < bestm[exp_best]) exp_best = k;
    exp_fired = bestm[exp_best] >= NORM_THRESH;
    exp_dec = 0;
    for (int k = 0; k < 4; k++) begin
      exp_m[k] = exp_fired ? bestm[k] - NORM_THRESH : bestm[k];
      exp_dec  = exp_dec | (pick[k] << k);
    end
  endtask

  task automatic applyStimulus(input bit rst, input bit iv, input bit fs, input logic [1:0] s,
                               input logic [19:0] mp);
    bit          acc;
    int          i;
    rec_t        r;
    logic [19:0] exp_new;
    @(negedge clk);
`ifdef ACS_NORM_STATS_EN
    if (nc_known) checkOutput("norm_cnt", norm_cnt, model_nc);
`endif
    reset       = rst;
    in_valid    = iv;
    frame_start = fs;
    sym         = s;
    {m_in3, m_in2, m_in1, m_in0} = mp;
    #1;
    if (rst) begin
      exp_new       = '0;
      model_running = 0;
      model_idx     = 0;
      model_nc      = 0;
      nc_known      = 1;
    end else begin
      acc = iv && (model_running || fs);
      if (!acc) begin
        exp_new = mp;
      end else begin
        for (int k = 0; k < 4; k++) model_old[k] = fs ? ((k == 0) ? 0 : INIT_BIAS) : int'(mp[5*k +: 5]);
        modelAcs(int'(s));
        exp_new = {5'(exp_m[3]), 5'(exp_m[2]), 5'(exp_m[1]), 5'(exp_m[0])};
        i      = fs ? 0 : model_idx;
        r.cyc  = cyc_cnt + 1;
        r.dec  = 4'(exp_dec);
        r.best = 2'(exp_best);
        r.idx  = CNT_W'(i);
        r.fd   = (i == FRAME_LEN - 1);
        sb_q.push_back(r);
        if (r.fd) begin
          model_running = 0;
          model_idx     = 0;
        end else begin
          model_running = 1;
          model_idx     = i + 1;
        end
        if (fs) model_nc = 0;
        if (exp_fired && model_nc < 255) model_nc++;
      end
    end
    checkOutput("m_new", {m_new3, m_new2, m_new1, m_new0}, exp_new);
  endtask

  task automatic checkRegs(input string nm, input logic [3:0] d, input logic [1:0] b,
                           input logic [CNT_W-1:0] idx, input bit fd, input bit dv);
    @(posedge clk);
    #2;
    checkOutput({nm, "_dec"}, dec, d);
    checkOutput({nm, "_best"}, best_state, b);
    checkOutput({nm, "_idx"}, sym_idx, idx);
    checkOutput({nm, "_frame_done"}, frame_done, fd);
    checkOutput({nm, "_dec_valid"}, dec_valid, dv);
  endtask

  // Monitor: consumes one expected record per dec_valid and flags missing or stray outputs.
  initial begin
    rec_t r;
    forever begin
      @(posedge clk);
      cyc_cnt++;
      #1;
      if (mon_en) begin
        if (dec_valid === 1'b1) begin
          if (sb_q.size() == 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL sb_unexpected: dec_valid=1 at cycle %0d, required no output", cyc_cnt);
          end else begin
            r = sb_q.pop_front();
            checkOutput("sb_cycle", cyc_cnt, r.cyc);
            checkOutput("sb_dec", dec, r.dec);
            checkOutput("sb_best", best_state, r.best);
            checkOutput("sb_idx", sym_idx, r.idx);
            checkOutput("sb_frame_done", frame_done, r.fd);
          end
        end else begin
          if (sb_q.size() > 0 && sb_q[0].cyc <= cyc_cnt) begin
            tests++;
            fails++;
            $display("[TB] FAIL sb_missing: dec_valid=%b at cycle %0d, required 1", dec_valid, cyc_cnt);
            void'(sb_q.pop_front());
          end
          checkOutput("sb_stray_frame_done", frame_done, 1'b0);
        end
      end
    end
  end

  localparam logic [19:0] ALL31 = {5'd31, 5'd31, 5'd31, 5'd31};
  localparam logic [19:0] SCN3  = {5'd17, 5'd17, 5'd16, 5'd20};

  initial begin
    logic [19:0] mp;
    bit          rst, iv, fs;
    reset = 1'b1; in_valid = 1'b0; frame_start = 1'b0; sym = 2'b00;
    m_in0 = '0; m_in1 = '0; m_in2 = '0; m_in3 = '0;

    applyStimulus(1, 1, 1, 2'b11, 20'($urandom));
    applyStimulus(1, 1, 0, 2'b01, 20'($urandom));
    mon_en = 1;
    applyStimulus(1, 1, 1, 2'b10, 20'($urandom));
    checkRegs("reset", 4'b0000, 2'd0, '0, 1'b0, 1'b0);

    mp = 20'($urandom);
    applyStimulus(0, 1, 0, 2'b01, mp);
    checkOutput("idle_hold_m_new", {m_new3, m_new2, m_new1, m_new0}, mp);
    checkRegs("idle_ignore", 4'b0000, 2'd0, '0, 1'b0, 1'b0);

    applyStimulus(0, 1, 1, 2'b00, ALL31);
    checkOutput("scn2_m_new", {m_new3, m_new2, m_new1, m_new0}, {5'd9, 5'd2, 5'd9, 5'd0});
    checkRegs("scn2", 4'b0000, 2'd0, 8'd0, 1'b0, 1'b1);

    applyStimulus(0, 1, 0, 2'b11, SCN3);
    checkOutput("scn3_m_new", {m_new3, m_new2, m_new1, m_new0}, {5'd2, 5'd2, 5'd2, 5'd0});
    checkRegs("scn3", 4'b0101, 2'd0, 8'd1, 1'b0, 1'b1);

    applyStimulus(0, 1, 0, 2'b00, ALL31);
    checkOutput("scn4_m_new", {m_new3, m_new2, m_new1, m_new0}, {5'd15, 5'd15, 5'd15, 5'd15});
    checkRegs("scn4", 4'b0000, 2'd0, 8'd2, 1'b0, 1'b1);

    applyStimulus(0, 1, 0, 2'($urandom), 20'($urandom));
    @(posedge clk);
    #2;
    checkOutput("last_idx", sym_idx, 8'd3);
    checkOutput("last_frame_done", frame_done, 1'b1);
    checkOutput("last_dec_valid", dec_valid, 1'b1);

    mp = 20'($urandom);
    applyStimulus(0, 1, 0, 2'b10, mp);
    checkOutput("post_frame_hold", {m_new3, m_new2, m_new1, m_new0}, mp);
    @(posedge clk);
    #2;
    checkOutput("post_frame_dec_valid", dec_valid, 1'b0);

    applyStimulus(0, 1, 1, 2'b00, ALL31);
    applyStimulus(0, 1, 0, 2'b00, ALL31);
    applyStimulus(0, 1, 1, 2'b00, ALL31);
    checkOutput("restart_m_new", {m_new3, m_new2, m_new1, m_new0}, {5'd9, 5'd2, 5'd9, 5'd0});
    checkRegs("restart", 4'b0000, 2'd0, 8'd0, 1'b0, 1'b1);
`ifdef ACS_NORM_STATS_EN
    checkOutput("restart_norm_cnt", norm_cnt, 8'd0);
`endif
    applyStimulus(0, 1, 0, 2'b11, SCN3);
    @(posedge clk);
    #2;
    checkOutput("restart_scn3_idx", sym_idx, 8'd1);
`ifdef ACS_NORM_STATS_EN
    checkOutput("restart_scn3_norm_cnt", norm_cnt, 8'd1);
`endif

    for (int n = 0; n < 400; n++) begin
      rst = $urandom_range(0, 99) < 2;
      iv  = $urandom_range(0, 99) < 75;
      fs  = $urandom_range(0, 99) < 12;
      for (int k = 0; k < 4; k++) begin
        mp[5*k +: 5] = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(14, 31))
                                                    : 5'($urandom_range(0, 31));
      end
      applyStimulus(rst, iv, fs, 2'($urandom), mp);
    end

    for (int n = 0; n < 3; n++) applyStimulus(0, 0, 0, 2'b00, '0);
    checkOutput("queue_drained", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/acs_unit.md
Name: acs_unit

Overview:
- Add-compare-select stage of the K=3, rate-1/2 (generators 7,5 octal) Viterbi decoder.
- Consumes the four registered 5-bit path metrics from the path-metric register (m_in0..3) and one hard-decision received symbol.
- Computes the four next metrics (m_new0..3) combinationally and returns them to that register's inputs, closing the metric loop.
- Also registers survivor decisions for traceback, tracks frame position, and normalizes metrics.

Parameters:
- FRAME_LEN, 64: symbols per frame. Must be ≥2.
- INIT_BIAS, 8: starting metric for states 1..3 on frame start. State 0 starts at 0.
- NORM_THRESH, 16: if the minimum next metric is ≥ this value, subtract this value from all four.
- CNT_W, 8: width of sym_idx. 2^CNT_W must be ≥ FRAME_LEN.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  a received symbol is present this cycle
- frame_start  input  1  qualified by in_valid: this symbol is the first of a frame
- sym  input  2  received hard bits {r1,r0}
- m_in0..m_in3  input  5 each  current path metrics from the metric register
- m_new0..m_new3  output  5 each  next path metrics (combinational) to the metric register
- dec  output  4  registered survivor decisions; bit i belongs to state i
- dec_valid  output  1  registered: dec, best_state and sym_idx are valid
- best_state  output  2  registered index of the smallest next metric
- sym_idx  output  CNT_W  registered index of the decided symbol within its frame
- frame_done  output  1  registered one-cycle pulse, concurrent with the last dec_valid of a frame

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values:
  - State machine goes to IDLE; the internal counter clears.
  - dec=0, dec_valid=0, best_state=0, sym_idx=0, frame_done=0.
  - While reset is high, m_new0..3 are driven to 0.
- Trellis definition:
  - State s = {b1,b2}. Next state n = {u,b1}.
  - Predecessors of n: p0 = {n[0],0} and p1 = {n[0],1}.
  - Expected code symbol for transition p→n: c1 = n[1]^p[1]^p[0], c0 = n[1]^p[0].
  - Branch metric bm = Hamming distance between {c1,c0} and sym, range 0..2.
- Arithmetic (per state n):
  - Candidate metrics a = old[p0]+bm0 and b = old[p1]+bm1, computed at 6 bits and saturated to 31.
  - Select: new = min(a,b). dec bit = 1 only when b < a; a tie selects p0 (dec bit 0).
  - Normalize: if min over all four new metrics ≥ NORM_THRESH, subtract NORM_THRESH from all four.
  - The values after normalization drive m_new.
- Source of old metrics:
  - Accepted symbol with frame_start=1: old = {0, INIT_BIAS, INIT_BIAS, INIT_BIAS}; m_in is ignored.
  - Any other accepted symbol: old = m_in.
- Acceptance rules:
  - A symbol is accepted when in_valid=1 AND (state=RUN OR frame_start=1).
  - When no symbol is accepted, m_new = m_in (metrics hold) and dec_valid=0 on the next cycle.
- State machine:
  - IDLE → RUN on in_valid & frame_start. This loads the count to 1.
  - In RUN, each accepted symbol increments the count.
  - The accepted symbol whose index is FRAME_LEN-1 sets frame_done for the following cycle and returns the machine to IDLE.
  - in_valid without frame_start in IDLE is ignored.
  - frame_start during RUN restarts the frame: init metrics, index 0, no frame_done for the aborted frame.
- Latency:
  - dec, dec_valid, best_state, sym_idx and frame_done update on the clock edge after acceptance.
  - This is the same edge on which the metric register captures m_new.
- best_state tie-break: lowest state index wins.
- Reset mid-frame: the frame is abandoned; outputs take their reset values the next cycle.

Optional Feature:
- Macro: ACS_NORM_STATS_EN.
- When defined:
  - Adds output port norm_cnt [7:0], counting accepted symbols on which normalization fired.
  - The count saturates at 255.
  - It clears on reset and on any accepted frame_start symbol; the count for that symbol restarts from 0 or 1.
- When undefined: no port and no logic.

Test Plan:
- Reset held 3 cycles with in_valid=1 → m_new all 0, dec_valid=0, frame_done=0, sym_idx=0. After release, in_valid without frame_start → m_new==m_in, dec_valid stays 0.
- frame_start=1, sym=00, m_in=31 on all → m_new={0,9,2,9}. Next cycle: dec=0000, best_state=0, sym_idx=0, dec_valid=1.
- RUN, sym=11, m_in={20,16,17,17} → normalization fires; m_new={0,2,2,2}. Next cycle: dec=0101, best_state=0.
- RUN, sym=00, m_in all 31 → candidates saturate to 31; normalized m_new all 15; dec=0000.
- FRAME_LEN=4, four back-to-back symbols starting with frame_start → sym_idx 0,1,2,3. frame_done pulses together with the dec_valid for index 3. A fifth in_valid without frame_start → dec_valid=0 and metrics held.
- frame_start re-asserted at index 2 → sym_idx returns to 0, m_new reinitialised as in scenario 2, no frame_done. With ACS_NORM_STATS_EN defined, norm_cnt clears and then counts the scenario-3 case as 1.
